// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel front end (window generator) and the Sobel core.
package sobel_pkg;

  localparam int PIX_W     = 8;
  localparam int CNT_W     = 10;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  // window[r][c]: row 0 = top, col 0 = left
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage: read-before-write at a single address, unregistered read port.
module sobel_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are deliberately unreset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds interior 3x3 neighbourhoods from a raster pixel stream for the Sobel core.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_i,
  input  logic             pixel_en_i,
  output logic [PIX_W-1:0] data_0_0_o,
  output logic [PIX_W-1:0] data_0_1_o,
  output logic [PIX_W-1:0] data_0_2_o,
  output logic [PIX_W-1:0] data_1_0_o,
  output logic [PIX_W-1:0] data_1_1_o,
  output logic [PIX_W-1:0] data_1_2_o,
  output logic [PIX_W-1:0] data_2_0_o,
  output logic [PIX_W-1:0] data_2_1_o,
  output logic [PIX_W-1:0] data_2_2_o,
  output logic             core_en_o,
  output logic [CNT_W-1:0] cnt_col_o,
  output logic [CNT_W-1:0] cnt_row_o,
  output logic             frame_done_o
);

  localparam int ADDR_W = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  logic [CNT_W-1:0]      in_col;
  logic [CNT_W-1:0]      in_row;
  window_t               win_sr;
  window_t               win_out;
  logic [2:0][PIX_W-1:0] col_in;
  logic [PIX_W-1:0]      top_px;
  logic [PIX_W-1:0]      mid_px;
  logic                  accept;
  logic                  emit;
  logic                  last_px;

  // A pixel arriving together with reset is dropped, including its line-buffer write.
  assign accept  = pixel_en_i & ~rst;
  assign emit    = (in_row >= 10'd2) && (in_col >= 10'd2);
  assign last_px = (in_col == COL_LAST) && (in_row == ROW_LAST);

  assign col_in[0] = top_px;
  assign col_in[1] = mid_px;
  assign col_in[2] = pixel_i;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(ADDR_W)) u_lb_top (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (in_col[ADDR_W-1:0]),
    .wr_data (mid_px),
    .rd_data (top_px)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(ADDR_W)) u_lb_mid (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (in_col[ADDR_W-1:0]),
    .wr_data (pixel_i),
    .rd_data (mid_px)
  );

  // Input raster counters, column shift registers and the registered window outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col       <= {CNT_W{1'b0}};
      in_row       <= {CNT_W{1'b0}};
      win_sr       <= '0;
      win_out      <= '0;
      core_en_o    <= 1'b0;
      frame_done_o <= 1'b0;
      cnt_col_o    <= {CNT_W{1'b0}};
      cnt_row_o    <= {CNT_W{1'b0}};
    end else begin
      core_en_o    <= 1'b0;
      frame_done_o <= 1'b0;
      if (pixel_en_i) begin
        if (in_col == COL_LAST) begin
          in_col <= {CNT_W{1'b0}};
          in_row <= (in_row == ROW_LAST) ? {CNT_W{1'b0}} : in_row + 10'd1;
        end else begin
          in_col <= in_col + 10'd1;
        end
        for (int r = 0; r < 3; r++) begin
          win_sr[r][0] <= win_sr[r][1];
          win_sr[r][1] <= win_sr[r][2];
          win_sr[r][2] <= col_in[r];
        end
        // Old cols 1..2 plus the incoming column form the complete window.
        if (emit) begin
          core_en_o    <= 1'b1;
          frame_done_o <= last_px;
          cnt_row_o    <= in_row - 10'd1;
          cnt_col_o    <= in_col - 10'd1;
          for (int r = 0; r < 3; r++) begin
            win_out[r][0] <= win_sr[r][1];
            win_out[r][1] <= win_sr[r][2];
            win_out[r][2] <= col_in[r];
          end
        end
      end
    end
  end

  assign data_0_0_o = win_out[0][0];
  assign data_0_1_o = win_out[0][1];
  assign data_0_2_o = win_out[0][2];
  assign data_1_0_o = win_out[1][0];
  assign data_1_1_o = win_out[1][1];
  assign data_1_2_o = win_out[1][2];
  assign data_2_0_o = win_out[2][0];
  assign data_2_1_o = win_out[2][1];
  assign data_2_2_o = win_out[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 5x4 instance for most scenarios plus a 3x3 instance.
module tb_sobel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic       en3;
  logic [7:0] pix;
  logic [7:0] pix3;

  logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic       a_en, a_fd;
  logic [9:0] a_col, a_row;
  logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
  logic       b_en, b_fd;
  logic [9:0] b_col, b_row;

  wire [71:0] a_win = {a00, a01, a02, a10, a11, a12, a20, a21, a22};
  wire [71:0] b_win = {b00, b01, b02, b10, b11, b12, b20, b21, b22};

  int checks = 0;
  int errors = 0;

  int         cap_at[$];
  logic [9:0] cap_row[$];
  logic [9:0] cap_col[$];
  logic [71:0] cap_win[$];
  logic       cap_fd[$];
  int         fd_total;
  int         stall_viol;
  int         hold_viol;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pixel_i(pix), .pixel_en_i(en),
    .data_0_0_o(a00), .data_0_1_o(a01), .data_0_2_o(a02),
    .data_1_0_o(a10), .data_1_1_o(a11), .data_1_2_o(a12),
    .data_2_0_o(a20), .data_2_1_o(a21), .data_2_2_o(a22),
    .core_en_o(a_en), .cnt_col_o(a_col), .cnt_row_o(a_row), .frame_done_o(a_fd)
  );

  sobel_window_gen #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .pixel_i(pix3), .pixel_en_i(en3),
    .data_0_0_o(b00), .data_0_1_o(b01), .data_0_2_o(b02),
    .data_1_0_o(b10), .data_1_1_o(b11), .data_1_2_o(b12),
    .data_2_0_o(b20), .data_2_1_o(b21), .data_2_2_o(b22),
    .core_en_o(b_en), .cnt_col_o(b_col), .cnt_row_o(b_row), .frame_done_o(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ramp window centred at (cr, cc): pixel(r, c) = (r*16 + c) ^ xv
  function automatic logic [71:0] exp_win(input int cr, input int cc, input logic [7:0] xv);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w = {w[63:0], 8'((cr - 1 + r) * 16 + (cc - 1 + c)) ^ xv};
    return w;
  endfunction

  task automatic apply_reset(input int n);
    rst = 1'b1;
    en  = 1'b0;
    en3 = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Feeds n_pix ramp pixels into the 5x4 instance and records every strobe.
  task automatic stream(input logic [7:0] xv, input int stall_pct, input int n_pix);
    logic [91:0] snap;
    int r, c, ns;
    cap_at.delete(); cap_row.delete(); cap_col.delete(); cap_win.delete(); cap_fd.delete();
    fd_total = 0; stall_viol = 0; hold_viol = 0;
    for (int p = 0; p < n_pix; p++) begin
      r  = p / W;
      c  = p % W;
      ns = 0;
      while (stall_pct > 0 && ns < 4 && $urandom_range(0, 99) < stall_pct) begin
        snap = {a_win, a_row, a_col};
        en   = 1'b0;
        pix  = 8'($urandom_range(0, 255));
        tick();
        if (a_en !== 1'b0 || a_fd !== 1'b0) stall_viol++;
        if ({a_win, a_row, a_col} !== snap) hold_viol++;
        ns++;
      end
      en  = 1'b1;
      pix = 8'(r * 16 + c) ^ xv;
      tick();
      if (a_en === 1'b1) begin
        cap_at.push_back(p);
        cap_row.push_back(a_row);
        cap_col.push_back(a_col);
        cap_win.push_back(a_win);
        cap_fd.push_back(a_fd);
      end
      if (a_fd === 1'b1) fd_total++;
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pix = 8'hAB; en3 = 1'b1; pix3 = 8'hCD;
    tick(); tick();
    rst = 1'b0; en = 1'b0; en3 = 1'b0;
    checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL reset_core_en got %0h want 0", a_en); end
    checks++; if (a_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0h want 0", a_fd); end
    checks++; if (a_win !== 72'd0) begin errors++; $display("FAIL reset_data got %0h want 0", a_win); end
    checks++; if ({a_row, a_col} !== 20'd0) begin errors++; $display("FAIL reset_cnt got %0h want 0", {a_row, a_col}); end
    checks++; if ({b_en, b_fd, b_win, b_row, b_col} !== 94'd0) begin
      errors++; $display("FAIL reset_small got %0h want 0", {b_en, b_fd, b_win, b_row, b_col}); end
  endtask

  task automatic test_first_window();
    int first_at;
    apply_reset(1);
    stream(8'h00, 0, W * H);
    first_at = (cap_at.size() > 0) ? cap_at[0] : -1;
    checks++; if (first_at !== 12) begin errors++; $display("FAIL first_strobe_pixel got %0d want 12", first_at); end
    if (cap_at.size() > 0) begin
      checks++; if (cap_win[0][71:64] !== 8'h00) begin errors++; $display("FAIL first_d00 got %0h want 00", cap_win[0][71:64]); end
      checks++; if (cap_win[0][39:32] !== 8'h11) begin errors++; $display("FAIL first_d11 got %0h want 11", cap_win[0][39:32]); end
      checks++; if (cap_win[0][7:0] !== 8'h22) begin errors++; $display("FAIL first_d22 got %0h want 22", cap_win[0][7:0]); end
      checks++; if ({cap_row[0], cap_col[0]} !== {10'd1, 10'd1}) begin
        errors++; $display("FAIL first_centre got %0d,%0d want 1,1", cap_row[0], cap_col[0]); end
    end
  endtask

  // Uses the capture left by test_first_window.
  task automatic test_window_count();
    checks++; if (cap_at.size() !== 6) begin errors++; $display("FAIL window_count got %0d want 6", cap_at.size()); end
    for (int i = 0; i < cap_at.size() && i < 6; i++) begin
      checks++; if ({cap_row[i], cap_col[i]} !== {10'(1 + i / 3), 10'(1 + i % 3)}) begin
        errors++; $display("FAIL count_centre[%0d] got %0d,%0d want %0d,%0d", i, cap_row[i], cap_col[i], 1 + i / 3, 1 + i % 3); end
      checks++; if (cap_win[i] !== exp_win(1 + i / 3, 1 + i % 3, 8'h00)) begin
        errors++; $display("FAIL count_win[%0d] got %0h want %0h", i, cap_win[i], exp_win(1 + i / 3, 1 + i % 3, 8'h00)); end
    end
    checks++; if (fd_total !== 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", fd_total); end
    if (cap_at.size() == 6) begin
      checks++; if (cap_fd[5] !== 1'b1) begin errors++; $display("FAIL frame_done_last got %0h want 1", cap_fd[5]); end
      checks++; if (cap_win[5][7:0] !== 8'h34) begin errors++; $display("FAIL last_d22 got %0h want 34", cap_win[5][7:0]); end
    end
  endtask

  task automatic test_stall();
    apply_reset(1);
    stream(8'h00, 50, W * H);
    checks++; if (cap_at.size() !== 6) begin errors++; $display("FAIL stall_count got %0d want 6", cap_at.size()); end
    for (int i = 0; i < cap_at.size() && i < 6; i++) begin
      checks++; if ({cap_row[i], cap_col[i], cap_win[i]} !== {10'(1 + i / 3), 10'(1 + i % 3), exp_win(1 + i / 3, 1 + i % 3, 8'h00)}) begin
        errors++; $display("FAIL stall_window[%0d] got %0d,%0d %0h", i, cap_row[i], cap_col[i], cap_win[i]); end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_strobe got %0d want 0", stall_viol); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", hold_viol); end
  endtask

  task automatic test_back_to_back();
    apply_reset(1);
    stream(8'h00, 0, W * H);
    stream(8'hF0, 0, W * H);
    checks++; if (cap_at.size() !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", cap_at.size()); end
    if (cap_at.size() > 0) begin
      checks++; if (cap_at[0] !== 12) begin errors++; $display("FAIL b2b_first_pixel got %0d want 12", cap_at[0]); end
      checks++; if ({cap_row[0], cap_col[0]} !== {10'd1, 10'd1}) begin
        errors++; $display("FAIL b2b_centre got %0d,%0d want 1,1", cap_row[0], cap_col[0]); end
      checks++; if (cap_win[0][39:32] !== 8'hE1) begin errors++; $display("FAIL b2b_d11 got %0h want e1", cap_win[0][39:32]); end
    end
    for (int i = 0; i < cap_at.size() && i < 6; i++) begin
      checks++; if (cap_win[i] !== exp_win(1 + i / 3, 1 + i % 3, 8'hF0)) begin
        errors++; $display("FAIL b2b_win[%0d] got %0h want %0h", i, cap_win[i], exp_win(1 + i / 3, 1 + i % 3, 8'hF0)); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1);
    stream(8'h00, 0, 14);
    checks++; if (cap_at.size() !== 2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", cap_at.size()); end
    rst = 1'b1; en = 1'b1; pix = 8'h99;
    tick();
    rst = 1'b0; en = 1'b0;
    checks++; if ({a_en, a_fd, a_win, a_row, a_col} !== 94'd0) begin
      errors++; $display("FAIL mid_reset_outputs got %0h want 0", {a_en, a_fd, a_win, a_row, a_col}); end
    stream(8'h00, 0, W * H);
    checks++; if (cap_at.size() !== 6) begin errors++; $display("FAIL mid_count got %0d want 6", cap_at.size()); end
    if (cap_at.size() > 0) begin
      checks++; if (cap_at[0] !== 12) begin errors++; $display("FAIL mid_first_pixel got %0d want 12", cap_at[0]); end
    end
    for (int i = 0; i < cap_at.size() && i < 6; i++) begin
      checks++; if ({cap_row[i], cap_col[i], cap_win[i]} !== {10'(1 + i / 3), 10'(1 + i % 3), exp_win(1 + i / 3, 1 + i % 3, 8'h00)}) begin
        errors++; $display("FAIL mid_window[%0d] got %0d,%0d %0h", i, cap_row[i], cap_col[i], cap_win[i]); end
    end
  endtask

  task automatic test_small_image();
    int n = 0;
    int at = -1;
    logic [71:0] w = '0;
    logic [19:0] ctr = '0;
    logic fd = 1'b0;
    apply_reset(1);
    for (int p = 0; p < 9; p++) begin
      en3  = 1'b1;
      pix3 = 8'((p / 3) * 16 + p % 3);
      tick();
      if (b_en === 1'b1) begin
        n++; at = p; w = b_win; ctr = {b_row, b_col}; fd = b_fd;
      end
    end
    en3 = 1'b0;
    checks++; if (n !== 1) begin errors++; $display("FAIL small_count got %0d want 1", n); end
    checks++; if (at !== 8) begin errors++; $display("FAIL small_pixel got %0d want 8", at); end
    checks++; if (ctr !== {10'd1, 10'd1}) begin errors++; $display("FAIL small_centre got %0h want 00401", ctr); end
    checks++; if (w[71:64] !== 8'h00) begin errors++; $display("FAIL small_d00 got %0h want 00", w[71:64]); end
    checks++; if (w[7:0] !== 8'h22) begin errors++; $display("FAIL small_d22 got %0h want 22", w[7:0]); end
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL small_frame_done got %0h want 1", fd); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en3 = 1'b0; pix = 8'h00; pix3 = 8'h00;
    test_reset();
    test_first_window();
    test_window_count();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_small_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
